// File: rtl/command_fifo_pkg.sv
// Command-path types shared between the command FIFO and the decoder.
package command_fifo_pkg;

    localparam int unsigned packet_size = 32;

    typedef enum logic [1:0] {
        CMD_TYPE_0 = 2'b00,
        CMD_TYPE_1 = 2'b01,
        CMD_TYPE_2 = 2'b10,
        CMD_TYPE_3 = 2'b11
    } cmd_type_e;

    typedef struct packed {
        logic                   valid;
        logic [packet_size-1:0] packet;
    } com_packet;

    function automatic cmd_type_e packet_type(input logic [packet_size-1:0] p);
        return cmd_type_e'(p[packet_size-1 -: 2]);
    endfunction

endpackage

// File: rtl/command_fifo.sv
// Command FIFO: circular buffer feeding a presentation register that the
// decoder can hold via fifo_stall or replay_iter_flag.
module command_fifo
    import command_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    input  logic [packet_size-1:0] wr_packet,
    output logic                   wr_ready,
    input  logic                   flush,
    input  logic                   fifo_stall,
    input  logic                   replay_iter_flag,
    output com_packet              com2DPpacket,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [packet_size-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   pres_valid;
    logic [packet_size-1:0] pres_packet;
    logic                   push;
    logic                   pop;
    logic                   hold;

    assign wr_ready = (count < DEPTH_CNT);
    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0) && !pres_valid;

    always_comb begin
        hold = pres_valid && (fifo_stall || replay_iter_flag);
        push = wr_valid && wr_ready && !flush;
        pop  = !hold && (count != '0) && !flush;
    end

    always_comb begin
        com2DPpacket        = '0;
        com2DPpacket.valid  = pres_valid && !fifo_stall && !replay_iter_flag;
        com2DPpacket.packet = pres_packet;
    end

    // Held presentation register blocks the pop, so the decoder's one-cycle
    // stall latency never drops or repeats a command.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pres_valid  <= 1'b0;
            pres_packet <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pres_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                pres_packet <= mem[rd_ptr];
                pres_valid  <= 1'b1;
            end else if (!hold) begin
                pres_valid <= 1'b0;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_packet;
        end
    end

endmodule

// File: tb/tb_command_fifo.sv
// Self-checking bench for command_fifo: queue-based reference model plus an
// output scoreboard, with directed scenarios and randomized traffic.
module tb_command_fifo;
    import command_fifo_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic                   clk              = 1'b0;
    logic                   reset            = 1'b1;
    logic                   wr_valid         = 1'b0;
    logic [packet_size-1:0] wr_packet        = '0;
    logic                   flush            = 1'b0;
    logic                   fifo_stall       = 1'b0;
    logic                   replay_iter_flag = 1'b0;
    logic                   wr_ready;
    logic                   empty;
    logic                   full;
    com_packet              com2DPpacket;
    logic [$clog2(DEPTH):0] count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned seq      = 0;

    logic [packet_size-1:0] exp_q[$];
    logic [packet_size-1:0] store_q[$];
    logic                   m_pres_v = 1'b0;
    logic [packet_size-1:0] m_pres_w = '0;

    command_fifo #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_valid         (wr_valid),
        .wr_packet        (wr_packet),
        .wr_ready         (wr_ready),
        .flush            (flush),
        .fifo_stall       (fifo_stall),
        .replay_iter_flag (replay_iter_flag),
        .com2DPpacket     (com2DPpacket),
        .count            (count),
        .empty            (empty),
        .full             (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: storage is a queue, the presented word a single slot.
    initial begin : model
        bit acc;
        bit hld;
        forever begin
            @(negedge clk);
            #1;
            check("valid", 64'(com2DPpacket.valid), 64'(m_pres_v && !fifo_stall && !replay_iter_flag));
            check("count", 64'(count), 64'(store_q.size()));
            check("wr_ready", 64'(wr_ready), 64'(store_q.size() < DEPTH));
            check("full", 64'(full), 64'(store_q.size() == DEPTH));
            check("empty", 64'(empty), 64'(store_q.size() == 0 && !m_pres_v));
            if (m_pres_v) check("pres_packet", 64'(com2DPpacket.packet), 64'(m_pres_w));
            if (reset) begin
                store_q.delete();
                exp_q.delete();
                m_pres_v = 1'b0;
                m_pres_w = '0;
            end else if (flush) begin
                store_q.delete();
                exp_q.delete();
                m_pres_v = 1'b0;
            end else begin
                acc = wr_valid && (store_q.size() < DEPTH);
                hld = m_pres_v && (fifo_stall || replay_iter_flag);
                if (!hld && store_q.size() > 0) begin
                    m_pres_w = store_q.pop_front();
                    m_pres_v = 1'b1;
                end else if (!hld) begin
                    m_pres_v = 1'b0;
                end
                if (acc) begin
                    store_q.push_back(wr_packet);
                    exp_q.push_back(wr_packet);
                end
            end
        end
    end

    // Scoreboard monitor: every delivered command must be the oldest expected one.
    always @(negedge clk) begin
        if (com2DPpacket.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got %0h, expected no output at %0t",
                         com2DPpacket.packet, $time);
            end else begin
                check("scoreboard", 64'(com2DPpacket.packet), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive(input logic wv, input logic [packet_size-1:0] wp,
                         input logic st, input logic rp, input logic fl);
        wr_valid         = wv;
        wr_packet        = wp;
        fifo_stall       = st;
        replay_iter_flag = rp;
        flush            = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n, input logic st);
        for (int unsigned i = 0; i < n; i++) begin
            drive(1'b0, '0, st, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic expect_out(input string name, input logic ev, input logic [packet_size-1:0] ew);
        @(negedge clk);
        check({name, "_valid"}, 64'(com2DPpacket.valid), 64'(ev));
        if (ev) check({name, "_packet"}, 64'(com2DPpacket.packet), 64'(ew));
    endtask

    function automatic logic [packet_size-1:0] new_word(input logic [1:0] ty);
        seq++;
        return {ty, 14'($urandom), 16'(seq)};
    endfunction

    initial begin : stimulus
        logic [packet_size-1:0] w1, w2, w3;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_wr_ready", 64'(wr_ready), 64'(1));
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_full", 64'(full), 64'(0));
        check("rst_com2DP", 64'(com2DPpacket), 64'(0));
        tick();
        reset = 1'b0;
        idle(2, 1'b0);

        // Ordering and two-cycle latency
        drive(1'b1, 32'h0000_00A1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h0000_00A2, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h0000_00A3, 1'b0, 1'b0, 1'b0);
        expect_out("ord_a1", 1'b1, 32'h0000_00A1); tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        expect_out("ord_a2", 1'b1, 32'h0000_00A2); tick();
        expect_out("ord_a3", 1'b1, 32'h0000_00A3); tick();
        @(negedge clk);
        check("ord_empty", 64'(empty), 64'(1));
        tick();
        idle(2, 1'b0);

        // Stall raised one cycle after a type-01 packet is presented
        w1 = new_word(2'b01);
        w2 = new_word(2'b10);
        w3 = new_word(2'b11);
        drive(1'b1, w1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, w2, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, w3, 1'b0, 1'b0, 1'b0);
        expect_out("stl_p1", 1'b1, w1); tick();
        for (int unsigned i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            expect_out("stl_hold", 1'b0, '0); tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        expect_out("stl_p2", 1'b1, w2); tick();
        expect_out("stl_p3", 1'b1, w3); tick();
        expect_out("stl_done", 1'b0, '0); tick();
        idle(2, 1'b0);

        // Full: one word reaches the presentation register, sixteen fill storage
        for (int unsigned i = 0; i < DEPTH + 1; i++) begin
            drive(1'b1, new_word(2'(i)), 1'b1, 1'b0, 1'b0); tick();
        end
        drive(1'b1, new_word(2'b11), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("full_flag", 64'(full), 64'(1));
        check("full_wr_ready", 64'(wr_ready), 64'(0));
        check("full_count", 64'(count), 64'(DEPTH));
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("full_drop_count", 64'(count), 64'(DEPTH));
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("pop_count", 64'(count), 64'(DEPTH - 1));
        check("pop_wr_ready", 64'(wr_ready), 64'(1));
        tick();
        idle(30, 1'b0);

        // Replay hold for ten cycles
        w1 = new_word(2'b00);
        w2 = new_word(2'b01);
        w3 = new_word(2'b10);
        drive(1'b1, w1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, w2, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, w3, 1'b0, 1'b1, 1'b0);
        expect_out("rpl_hold", 1'b0, '0); tick();
        for (int unsigned i = 0; i < 9; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
            expect_out("rpl_hold", 1'b0, '0);
            check("rpl_count", 64'(count), 64'(2));
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        expect_out("rpl_release", 1'b1, w1); tick();
        idle(6, 1'b0);

        // Flush with count=5, pres_valid=1 and a same-cycle write
        for (int unsigned i = 0; i < 6; i++) begin
            drive(1'b1, new_word(2'(i)), 1'b1, 1'b0, 1'b0); tick();
        end
        drive(1'b1, 32'hDEAD_F00D, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("fl_pre_count", 64'(count), 64'(5));
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("fl_count", 64'(count), 64'(0));
        check("fl_empty", 64'(empty), 64'(1));
        tick();
        idle(5, 1'b0);

        // Random interleaved traffic with wrap-around
        for (int unsigned i = 0; i < 150; i++) begin
            drive(($urandom % 10) < 6, new_word(2'($urandom)), ($urandom % 4) == 0,
                  ($urandom % 10) == 0, 1'b0);
            tick();
        end
        idle(40, 1'b0);
        check("wrap_drained", 64'(exp_q.size()), 64'(0));

        // Random traffic with occasional flushes and a mid-stream reset
        for (int unsigned i = 0; i < 120; i++) begin
            drive(($urandom % 10) < 7, new_word(2'($urandom)), ($urandom % 3) == 0,
                  ($urandom % 8) == 0, ($urandom % 30) == 0);
            reset = (i == 60 || i == 61);
            tick();
        end
        reset = 1'b0;
        idle(40, 1'b0);
        check("final_drained", 64'(exp_q.size()), 64'(0));
        check("final_empty", 64'(empty), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
